// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, access sizes,
// funct3 load/store encodings and lane-offset helpers.
package mem_stage_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Byte offset within the 8-byte beat, with the low bits dropped to the access size.
    function automatic logic [2:0] lane_offset(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [2:0] off;
        case (size)
            SZ_B:    off = addr_lo;
            SZ_H:    off = {addr_lo[2:1], 1'b0};
            SZ_W:    off = {addr_lo[2], 2'b00};
            default: off = 3'b000;
        endcase
        return off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        return addr_lo != lane_offset(size, addr_lo);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering between the 64-bit data bus and the register file:
// store strobes/data placement and load lane extraction with sign/zero extension.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_rs2,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wstrb,
    output logic [63:0] o_wdata,
    output logic [63:0] o_load_data
);

    logic [7:0]  w_size_mask;
    logic [63:0] w_shifted;
    logic        w_sext;

    always_comb begin
        case (i_size)
            SZ_B:    w_size_mask = 8'h01;
            SZ_H:    w_size_mask = 8'h03;
            SZ_W:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
        o_wstrb   = w_size_mask << i_offset;
        o_wdata   = i_rs2 << {i_offset, 3'b000};
        w_shifted = i_rdata >> {i_offset, 3'b000};
        w_sext    = 1'b0;
        case (i_size)
            SZ_B: begin
                w_sext      = ~i_unsigned & w_shifted[7];
                o_load_data = {{56{w_sext}}, w_shifted[7:0]};
            end
            SZ_H: begin
                w_sext      = ~i_unsigned & w_shifted[15];
                o_load_data = {{48{w_sext}}, w_shifted[15:0]};
            end
            SZ_W: begin
                w_sext      = ~i_unsigned & w_shifted[31];
                o_load_data = {{32{w_sext}}, w_shifted[31:0]};
            end
            default: o_load_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: captures execute results, runs data-bus loads/stores with
// a ready handshake and timeout, resolves branches. Optional macro: MEM_MISALIGN_TRAP_EN.
//
// state    | meaning
// S_IDLE   | capture from execute when not stalled; non-memory ops retire here
// S_ACCESS | bus request held stable until ready or timeout; upstream stalled
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic [31:0] i_instruction,
    input  logic [63:0] i_pc,
    input  logic [63:0] i_rs2_value,
    input  logic [63:0] i_alu_result,
    input  logic [63:0] i_jmp_addr,
    input  logic        i_alu_zero,
    input  logic        i_branch,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    input  logic        i_mem_to_reg,
    input  logic        i_reg_write,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [63:0] o_dmem_addr,
    output logic [63:0] o_dmem_wdata,
    output logic [7:0]  o_dmem_wstrb,
    input  logic        i_dmem_ready,
    input  logic [63:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_pc_src,
    output logic [63:0] o_branch_target,
    output logic        o_wb_valid,
    output logic [31:0] o_instruction,
    output logic [4:0]  o_rd,
    output logic [63:0] o_alu_result,
    output logic [63:0] o_mem_data,
    output logic        o_mem_to_reg,
    output logic        o_reg_write,
    output logic        o_bus_error,
    output logic        o_misaligned
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [CW-1:0] r_count;

    logic [31:0] r_instr;
    logic [63:0] r_addr;
    logic [63:0] r_rs2;
    logic        r_is_store;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    logic        r_pc_src;
    logic [63:0] r_branch_target;
    logic        r_wb_valid;
    logic [31:0] r_wb_instr;
    logic [63:0] r_wb_alu;
    logic [63:0] r_wb_mem_data;
    logic        r_wb_mem_to_reg;
    logic        r_wb_reg_write;
    logic        r_bus_error;
    logic        r_misaligned;

    logic        w_capture;
    logic        w_mem_op;
    logic        w_trap;
    logic        w_expire;
    logic        w_done;
    logic [2:0]  w_offset;
    logic [7:0]  w_wstrb;
    logic [63:0] w_wdata;
    logic [63:0] w_load_data;
    logic        w_unused;

    assign w_unused  = ^i_pc;
    assign w_capture = (r_state == S_IDLE) && !i_stall;
    assign w_mem_op  = i_mem_read | i_mem_write;
    assign w_expire  = (r_count == CW'(TIMEOUT - 1));
    assign w_done    = (r_state == S_ACCESS) && (i_dmem_ready || w_expire);
    assign w_offset  = lane_offset(r_instr[13:12], r_addr[2:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_mem_op & is_misaligned(i_instruction[13:12], i_alu_result[2:0]);
`else
    assign w_trap = 1'b0;
`endif

    load_store_align u_align (
        .i_size      (r_instr[13:12]),
        .i_unsigned  (r_instr[14]),
        .i_offset    (w_offset),
        .i_rs2       (r_rs2),
        .i_rdata     (i_dmem_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_capture && w_mem_op && !w_trap) w_state_next = S_ACCESS;
            S_ACCESS: if (i_dmem_ready || w_expire)         w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;
        o_dmem_wstrb = '0;
        if (r_state == S_ACCESS) begin
            o_stall      = 1'b1;
            o_dmem_req   = 1'b1;
            o_dmem_we    = r_is_store;
            o_dmem_addr  = {r_addr[63:3], 3'b000};
            o_dmem_wdata = w_wdata;
            o_dmem_wstrb = w_wstrb;
        end
    end

    // Counts ACCESS cycles without ready; cleared whenever the FSM is not waiting.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if ((r_state == S_ACCESS) && !i_dmem_ready && !w_expire)
            r_count <= r_count + 1'b1;
        else
            r_count <= '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr         <= '0;
            r_addr          <= '0;
            r_rs2           <= '0;
            r_is_store      <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_pc_src        <= 1'b0;
            r_branch_target <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_instr      <= '0;
            r_wb_alu        <= '0;
            r_wb_mem_data   <= '0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_bus_error     <= 1'b0;
            r_misaligned    <= 1'b0;
        end else begin
            r_pc_src     <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
            if (w_capture) begin
                r_instr         <= i_instruction;
                r_addr          <= i_alu_result;
                r_rs2           <= i_rs2_value;
                r_is_store      <= i_mem_write;
                r_mem_to_reg    <= i_mem_to_reg;
                r_reg_write     <= i_reg_write;
                r_pc_src        <= i_branch & i_alu_zero;
                r_branch_target <= i_jmp_addr;
                if (!w_mem_op || w_trap) begin
                    r_wb_valid      <= 1'b1;
                    r_wb_instr      <= i_instruction;
                    r_wb_alu        <= i_alu_result;
                    r_wb_mem_to_reg <= i_mem_to_reg;
                    r_wb_reg_write  <= i_reg_write & !w_trap;
                    r_misaligned    <= w_trap;
                end
            end else if (w_done) begin
                r_wb_valid      <= 1'b1;
                r_wb_instr      <= r_instr;
                r_wb_alu        <= r_addr;
                r_wb_mem_to_reg <= r_mem_to_reg;
                // Ready on the expiring cycle still counts as success.
                r_wb_reg_write  <= r_reg_write & !r_is_store & i_dmem_ready;
                r_bus_error     <= !i_dmem_ready;
                if (i_dmem_ready && !r_is_store)
                    r_wb_mem_data <= w_load_data;
            end
        end
    end

    assign o_pc_src        = r_pc_src;
    assign o_branch_target = r_branch_target;
    assign o_wb_valid      = r_wb_valid;
    assign o_instruction   = r_wb_instr;
    assign o_rd            = r_wb_instr[11:7];
    assign o_alu_result    = r_wb_alu;
    assign o_mem_data      = r_wb_mem_data;
    assign o_mem_to_reg    = r_wb_mem_to_reg;
    assign o_reg_write     = r_wb_reg_write;
    assign o_bus_error     = r_bus_error;
    assign o_misaligned    = r_misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized ops checked
// against an arithmetic reference model of the load/store and handshake rules.
module tb_memory_stage;

    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic [31:0] i_instruction;
    logic [63:0] i_pc, i_rs2_value, i_alu_result, i_jmp_addr;
    logic        i_alu_zero, i_branch, i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write;
    logic        o_dmem_req, o_dmem_we;
    logic [63:0] o_dmem_addr, o_dmem_wdata;
    logic [7:0]  o_dmem_wstrb;
    logic        i_dmem_ready;
    logic [63:0] i_dmem_rdata;
    logic        o_stall, o_pc_src;
    logic [63:0] o_branch_target;
    logic        o_wb_valid;
    logic [31:0] o_instruction;
    logic [4:0]  o_rd;
    logic [63:0] o_alu_result, o_mem_data;
    logic        o_mem_to_reg, o_reg_write, o_bus_error, o_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    memory_stage #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_rs2_value(i_rs2_value),
        .i_alu_result(i_alu_result), .i_jmp_addr(i_jmp_addr),
        .i_alu_zero(i_alu_zero), .i_branch(i_branch), .i_mem_write(i_mem_write),
        .i_mem_read(i_mem_read), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_pc_src(o_pc_src), .o_branch_target(o_branch_target),
        .o_wb_valid(o_wb_valid), .o_instruction(o_instruction), .o_rd(o_rd),
        .o_alu_result(o_alu_result), .o_mem_data(o_mem_data), .o_mem_to_reg(o_mem_to_reg),
        .o_reg_write(o_reg_write), .o_bus_error(o_bus_error), .o_misaligned(o_misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // One full transaction; assumes entry at a negedge with i_stall=1.
    task automatic run_op(input logic [2:0] f3, input logic rd_f, input logic wr_f,
                          input logic br, input logic zr, input logic rw, input logic m2r,
                          input logic [63:0] addr, input logic [63:0] rs2,
                          input logic [63:0] rdata, input logic [63:0] jmp, input int delay);
        logic [31:0] ins;
        logic        mem, store, trap, done;
        int          nb, off, cyc, exp_cyc;
        logic [63:0] lane_mask, ld, exp_wdata;
        logic [15:0] strb;
        ins = $urandom;
        ins[14:12] = f3;
        i_instruction = ins;  i_pc = {$urandom, $urandom};
        i_rs2_value = rs2;    i_alu_result = addr;  i_jmp_addr = jmp;
        i_alu_zero = zr;      i_branch = br;
        i_mem_read = rd_f;    i_mem_write = wr_f;
        i_mem_to_reg = m2r;   i_reg_write = rw;
        i_dmem_ready = 1'b0;  i_stall = 1'b0;
        tick();
        i_stall = 1'b1;

        mem   = rd_f | wr_f;
        store = wr_f;
        nb    = 1 << f3[1:0];
        off   = int'(addr[2:0]) - (int'(addr[2:0]) % nb);
`ifdef MEM_MISALIGN_TRAP_EN
        trap  = mem && ((int'(addr[2:0]) % nb) != 0);
`else
        trap  = 1'b0;
`endif
        chk("pc_src", o_pc_src, br & zr);
        chk("branch_target", o_branch_target, jmp);

        if (!mem || trap) begin
            chk("stall_idle", o_stall, 0);
            chk("req_idle", o_dmem_req, 0);
            chk("wb_valid", o_wb_valid, 1);
            chk("alu_result", o_alu_result, addr);
            chk("rd", o_rd, ins[11:7]);
            chk("mem_to_reg", o_mem_to_reg, m2r);
            chk("reg_write", o_reg_write, rw & !trap);
            chk("misaligned", o_misaligned, trap);
        end else begin
            strb = ((16'd1 << nb) - 16'd1) << off;
            exp_wdata = rs2 << (8 * off);
            chk("stall_access", o_stall, 1);
            chk("req", o_dmem_req, 1);
            chk("we", o_dmem_we, store);
            chk("dmem_addr", o_dmem_addr, addr & ~64'd7);
            chk("wstrb", o_dmem_wstrb, strb[7:0]);
            if (store) chk("wdata", o_dmem_wdata, exp_wdata);
            chk("wb_valid_low", o_wb_valid, 0);

            cyc  = 1;
            done = 1'b0;
            while (!done && cyc <= TMO + 2) begin
                i_dmem_ready = (cyc == delay);
                i_dmem_rdata = rdata;
                tick();
                i_dmem_ready = 1'b0;
                if (o_stall) begin
                    cyc++;
                    if (o_pc_src) chk("pc_src_access", o_pc_src, 0);
                end else begin
                    done = 1'b1;
                end
            end
            chk("access_bound", done, 1);
            exp_cyc = (delay <= TMO) ? delay : TMO;
            chk("stall_cycles", cyc, exp_cyc);
            chk("req_drop", o_dmem_req, 0);
            chk("wb_valid_done", o_wb_valid, 1);
            chk("bus_error", o_bus_error, delay > TMO);
            chk("reg_write_mem", o_reg_write, rw & !store & (delay <= TMO));
            chk("rd_mem", o_rd, ins[11:7]);
            chk("alu_result_mem", o_alu_result, addr);
            if (!store && delay <= TMO) begin
                lane_mask = (nb == 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
                ld = (rdata >> (8 * off)) & lane_mask;
                if (!f3[2] && nb < 8 && ld[8*nb-1]) ld = ld | ~lane_mask;
                chk("mem_data", o_mem_data, ld);
            end
        end
        // Stalled IDLE cycle: pulses must clear.
        tick();
        chk("wb_valid_pulse", o_wb_valid, 0);
        chk("pc_src_pulse", o_pc_src, 0);
        chk("bus_error_pulse", o_bus_error, 0);
    endtask

    initial begin
        i_rst = 1'b1;  i_stall = 1'b1;  i_instruction = '0;  i_pc = '0;
        i_rs2_value = '0;  i_alu_result = '0;  i_jmp_addr = '0;
        i_alu_zero = 0;  i_branch = 0;  i_mem_write = 0;  i_mem_read = 0;
        i_mem_to_reg = 0;  i_reg_write = 0;  i_dmem_ready = 0;  i_dmem_rdata = '0;
        repeat (3) tick();
        chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_alu", o_alu_result, 0);
        chk("rst_wstrb", o_dmem_wstrb, 0);
        i_rst = 1'b0;
        tick();

        // f3, rd, wr, br, zr, rw, m2r, addr, rs2, rdata, jmp, delay
        run_op(3'b000, 0, 0, 0, 0, 1, 0, 64'h1234, 64'h0, 64'h0, 64'h0, 1);
        run_op(3'b000, 1, 0, 0, 0, 1, 1, 64'h1003, 64'h0, 64'h1122_3344_8033_2211, 64'h0, 3);
        run_op(3'b100, 1, 0, 0, 0, 1, 1, 64'h1003, 64'h0, 64'h1122_3344_8033_2211, 64'h0, 3);
        run_op(3'b010, 0, 1, 0, 0, 1, 0, 64'h1004, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h0, 2);
        run_op(3'b000, 0, 0, 1, 1, 0, 0, 64'h0, 64'h0, 64'h0, 64'h2000, 1);
        run_op(3'b000, 0, 0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h2000, 1);
        run_op(3'b011, 1, 0, 0, 0, 1, 1, 64'h3000, 64'h0, 64'h5555_6666_7777_8888, 64'h0, 99);
        run_op(3'b011, 1, 0, 0, 0, 1, 1, 64'h3008, 64'h0, 64'h5555_6666_7777_8888, 64'h0, TMO);
        run_op(3'b010, 1, 0, 0, 0, 1, 1, 64'h1002, 64'h0, 64'hAAAA_BBBB_8765_4321, 64'h0, 1);
        run_op(3'b001, 1, 1, 0, 0, 1, 0, 64'h2006, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1);

        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [2:0]  f3;
            logic        rdf, wrf;
            int          dly;
            kind = $urandom_range(0, 3);
            rdf = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
            wrf = (kind == 3);
            f3  = wrf ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(1, 5);
            run_op(f3, rdf, wrf, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, dly);
        end

        // Reset while an access is outstanding.
        i_instruction = 32'h0000_2283;  i_alu_result = 64'h4000;
        i_mem_read = 1;  i_mem_write = 0;  i_branch = 1;  i_alu_zero = 1;
        i_jmp_addr = 64'h5000;  i_reg_write = 1;  i_stall = 0;
        tick();
        i_stall = 1;
        chk("pre_rst_req", o_dmem_req, 1);
        i_rst = 1'b1;
        tick();
        chk("rst_access_req", o_dmem_req, 0);
        chk("rst_access_stall", o_stall, 0);
        chk("rst_access_wb_valid", o_wb_valid, 0);
        chk("rst_access_target", o_branch_target, 0);
        chk("rst_access_pc_src", o_pc_src, 0);
        chk("rst_access_reg_write", o_reg_write, 0);
        chk("rst_access_instr", o_instruction, 0);
        i_rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
